vga_vram_arbiter: RTL and testbench
===================================

// Module: vga_vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM between the VGA display fetch path and a pixel writer
//  (drawing engine/CPU). Display reads are time-slot scheduled and always win. The writer gets every
//  other RAM cycle through a valid/ready handshake. Sits between VGA_Sync (pixel_x/pixel_y/video_on)
//  and the RGB outputs in the 25 MHz domain. Replaces the pixel generation circuit when a framebuffer is used.
// PARAMETERS
//  FB_W      160  framebuffer width in pixels (display is 640 wide, 4x horizontal replication)
//  FB_H      120  framebuffer height in lines (display is 480 high, 4x vertical replication)
//  ADDR_W    15   RAM address width; must satisfy 2**ADDR_W >= FB_W*FB_H (19200)
//  DATA_W    12   RAM word = {red[3:0],green[3:0],blue[3:0]}
// PORTS
//  clk          in   1       25 MHz pixel clock (same clock as VGA_Sync)
//  reset        in   1       synchronous, active-low reset
//  pixel_x      in   16      current column from VGA_Sync, 0..799
//  pixel_y      in   16      current row from VGA_Sync, 0..524
//  video_on     in   1       active-area flag from VGA_Sync
//  wr_valid     in   1       writer request
//  wr_ready     out  1       writer grant; transfer completes on valid&&ready at rising clk
//  wr_addr      in   ADDR_W  framebuffer address, y*FB_W+x
//  wr_data      in   DATA_W  pixel to store
//  wr_err       out  1       one-cycle pulse: accepted write had wr_addr >= FB_W*FB_H (dropped)
//  ram_addr     out  ADDR_W  RAM address (combinational from slot decode/writer inputs)
//  ram_we       out  1       RAM write enable
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid the cycle after ram_addr (1-cycle BRAM latency)
//  red,green,blue out 4 each registered pixel output
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): red/green/blue=0, pixel_cur=pixel_next=0, wr_ready=0, wr_err=0, ram_we=0.
//  - Slot = pixel_x[1:0]. Each 4-pixel group has one display-owned fetch cycle, at slot 1.
//  - Fetch is needed when slot==1 and either (a) pixel_x<640 and pixel_y<480, which fetches group
//    (pixel_x>>2)+1 of row pixel_y>>2 and is skipped at group 159, or (b) pixel_x==797, which prefetches
//    group 0 of the next line. The next line is (pixel_y+1) mod 525. A next line >=480 gives no fetch.
//  - Fetch address = (line>>2)*FB_W + group. Here FB_W=160 is computed as (r<<7)+(r<<5); no multiplier.
//  - Ownership FSM, evaluated per cycle: DISP when a fetch is needed, otherwise WR.
//    In DISP, ram_addr=fetch addr, ram_we=0, wr_ready=0.
//    In WR, wr_ready=1 and ram_addr=wr_addr. ram_we=wr_valid && wr_addr<FB_W*FB_H.
//  - Edge sampling slot 2 after a fetch: pixel_next <= ram_rdata.
//  - Edge sampling slot 0: pixel_cur <= pixel_next.
//  - Output, registered at every edge: if video_on, rgb <= (slot==0 ? pixel_next : pixel_cur);
//    otherwise rgb <= 0. Latency is 1 clk from pixel_x/video_on to rgb, so the top level delays
//    h_sync/v_sync by 1 clk.
//  - Writer rules: the writer holds wr_addr/wr_data stable while wr_valid && !wr_ready.
//    wr_ready never depends combinationally on wr_valid.
//  - Guaranteed writer bandwidth: 3 of 4 cycles in active lines, and all cycles in vblank except
//    pixel_x==797 on line 524.
//  - Out-of-range write: handshake completes, RAM is untouched, wr_err pulses 1 cycle later.
//  - Reset mid-line: state is cleared; display shows black until the next fetch refills pixel_next.
// CONFIGURATION
//  VGA_ARB_READBACK_EN defined adds the following ports:
//    wr_cmd (in, 1): 0 = write, 1 = read.
//    rd_valid (out, 1) and rd_data (out, DATA_W).
//  A read is accepted like a write but with ram_we=0. rd_valid pulses exactly 1 cycle after
//  acceptance, with rd_data=ram_rdata. Out-of-range reads return 0 and pulse wr_err.
//  Not defined: wr_cmd, rd_valid and rd_data are absent, and every transfer is a write.
// STRUCTURE
//  - Package vga_pkg holds H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, PREFETCH_X=797,
//    the own_t enum {OWN_DISP, OWN_WR} and the rgb444 packing function.
//  - One sub-module, vga_fetch_addr: purely combinational. It takes pixel_x/pixel_y and produces
//    fetch_needed and fetch_addr.
// TESTING
//  1. Reset held 2 clks with wr_valid=1. Expect wr_ready=0, rgb=0 and ram_we=0 throughout.
//  2. Preload RAM[0]=12'hF00 and RAM[1]=12'h0F0, then run to line 0. Expect pixel_x 0..3 to give
//     red=F and pixel_x 4..7 to give green=F, each 1 clk after pixel_x. Expect rgb=0 at pixel_x>=640.
//  3. Hold wr_valid=1 on an active line. Expect wr_ready=0 exactly when pixel_x[1:0]==1 and x<636.
//     Expect 3 writes per 4 clks, with addr/data held through the stall.
//  4. Write addr 19200. Expect the handshake to complete, ram_we=0 and wr_err=1 for 1 clk.
//  5. At pixel_y=524, pixel_x=797: expect ram_addr=0, ram_we=0, wr_ready=0.
//     At pixel_y=479, pixel_x=797: expect no fetch and wr_ready=1.
//  6. With VGA_ARB_READBACK_EN defined, write 12'hABC at addr 100, then read addr 100.
//     Expect rd_valid 1 clk after acceptance with rd_data=12'hABC.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, RAM ownership encoding and RGB444 packing helper
// for the framebuffer arbiter.
package vga_pkg;
  localparam logic [15:0] H_ACTIVE   = 16'd640;
  localparam logic [15:0] H_TOTAL    = 16'd800;
  localparam logic [15:0] V_ACTIVE   = 16'd480;
  localparam logic [15:0] V_TOTAL    = 16'd525;
  localparam logic [15:0] PREFETCH_X = 16'd797;

  typedef enum logic {OWN_DISP, OWN_WR} own_t;

  function automatic logic [11:0] rgb444(input logic [3:0] r, input logic [3:0] g,
                                         input logic [3:0] b);
    return {r, g, b};
  endfunction
endpackage

// File: rtl/vga_fetch_addr.sv
// Display fetch slot decoder: flags the slot-1 cycle that needs a RAM read and
// forms the framebuffer address (row*160 + group) without a multiplier.
module vga_fetch_addr
  import vga_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [15:0]       pixel_x,
  input  logic [15:0]       pixel_y,
  output logic              fetch_needed,
  output logic [ADDR_W-1:0] fetch_addr
);
  logic [15:0] next_y;
  logic [6:0]  row;
  logic [7:0]  group;

  always_comb begin
    fetch_needed = 1'b0;
    row          = '0;
    group        = '0;
    next_y       = (pixel_y == V_TOTAL - 16'd1) ? '0 : pixel_y + 16'd1;
    if (pixel_x[1:0] == 2'd1) begin
      if (pixel_x < H_ACTIVE && pixel_y < V_ACTIVE) begin
        // Fetch one group ahead; the last group on a line has nothing left to fetch.
        if (pixel_x[9:2] != 8'd159) begin
          fetch_needed = 1'b1;
          row          = pixel_y[8:2];
          group        = pixel_x[9:2] + 8'd1;
        end
      end else if (pixel_x == PREFETCH_X && next_y < V_ACTIVE) begin
        fetch_needed = 1'b1;
        row          = next_y[8:2];
        group        = '0;
      end
    end
    fetch_addr = ADDR_W'({row, 7'd0}) + ADDR_W'({row, 5'd0}) + ADDR_W'(group);
  end
endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch owns slot 1 of each 4-pixel group, the
// writer gets the rest. Define VGA_ARB_READBACK_EN to add writer read-back ports.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pixel_x,
  input  logic [15:0]       pixel_y,
  input  logic              video_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
`ifdef VGA_ARB_READBACK_EN
  input  logic              wr_cmd,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W + 1)'(FB_W * FB_H);

  own_t              own, own_q;
  logic              fetch_needed;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        slot;
  logic              in_range;
  logic              is_write;
  logic              accept;
  logic [DATA_W-1:0] pixel_cur, pixel_next, rgb_q;

  vga_fetch_addr #(.ADDR_W(ADDR_W)) u_fetch (
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .fetch_needed (fetch_needed),
    .fetch_addr   (fetch_addr)
  );

  assign slot     = pixel_x[1:0];
  assign in_range = {1'b0, wr_addr} < FB_SIZE;
  assign accept   = wr_valid && wr_ready;
`ifdef VGA_ARB_READBACK_EN
  assign is_write = !wr_cmd;
`else
  assign is_write = 1'b1;
`endif

  // Previous-cycle owner marks the cycle whose ram_rdata belongs to the display.
  always_ff @(posedge clk) begin
    if (!reset) own_q <= OWN_WR;
    else        own_q <= own;
  end

  always_comb begin
    own = fetch_needed ? OWN_DISP : OWN_WR;
  end

  always_comb begin
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = fetch_addr;
    ram_wdata = wr_data;
    if (own == OWN_WR) begin
      ram_addr = wr_addr;
      wr_ready = reset;
      ram_we   = reset && wr_valid && in_range && is_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pixel_cur  <= '0;
      pixel_next <= '0;
      rgb_q      <= '0;
      wr_err     <= 1'b0;
    end else begin
      if (slot == 2'd2 && own_q == OWN_DISP) pixel_next <= ram_rdata;
      if (slot == 2'd0) pixel_cur <= pixel_next;
      // Slot 0 shows the freshly fetched group while pixel_cur is being updated.
      rgb_q  <= video_on ? ((slot == 2'd0) ? pixel_next : pixel_cur) : '0;
      wr_err <= accept && !in_range;
    end
  end

`ifdef VGA_ARB_READBACK_EN
  logic rd_oor_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      rd_valid <= accept && wr_cmd;
      rd_oor_q <= !in_range;
    end
  end

  assign rd_data = (rd_valid && !rd_oor_q) ? ram_rdata : '0;
`endif

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a 1-cycle-latency RAM model;
// covers read-back when VGA_ARB_READBACK_EN is defined.
module tb_vga_vram_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] px = '0, py = '0;
  logic        video_on = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [14:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_err;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata = '0;
  logic [3:0]  red, green, blue;
`ifdef VGA_ARB_READBACK_EN
  logic        wr_cmd = 1'b0;
  logic        rd_valid;
  logic [11:0] rd_data;
`endif

  bit   [11:0] mem [0:32767];
  logic        pre_we = 1'b0;
  logic [14:0] pre_addr = '0;
  logic [11:0] pre_data = '0;

  int n_chk = 0, n_bad = 0, n_acc = 0;
  bit auto_wr = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  vga_vram_arbiter #(.FB_W(160), .FB_H(120), .ADDR_W(15), .DATA_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_x   (px),
    .pixel_y   (py),
    .video_on  (video_on),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
`ifdef VGA_ARB_READBACK_EN
    .wr_cmd    (wr_cmd),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
`endif
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (x=%0d y=%0d)", tag, got, exp, px, py);
    end
  endtask

  task automatic set_video();
    video_on = (px < 16'd640) && (py < 16'd480);
  endtask

  task automatic adv();
    logic acc;
    acc = wr_valid && wr_ready;
    @(posedge clk);
    #1;
    if (auto_wr && acc) begin
      n_acc++;
      wr_addr = wr_addr + 15'd1;
      wr_data = wr_data + 12'd1;
    end
    if (px == 16'd799) begin
      px = '0;
      py = (py == 16'd524) ? '0 : py + 16'd1;
    end else begin
      px = px + 16'd1;
    end
    set_video();
    #1;
  endtask

  task automatic goto_px(input logic [15:0] x, input logic [15:0] y);
    @(posedge clk);
    #1;
    px = x;
    py = y;
    set_video();
    #1;
  endtask

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    logic [15:0] prevx;
    logic [11:0] exp_rgb;

    // Reset with the writer requesting; RAM preloaded while held.
    wr_valid = 1'b1;
    wr_addr  = 15'd5;
    wr_data  = 12'h123;
    video_on = 1'b1;
    preload(15'd0,   12'hF00);
    preload(15'd1,   12'h0F0);
    preload(15'd159, 12'hFFF);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check("rst_wr_ready", wr_ready, 1'b0);
      check("rst_ram_we", ram_we, 1'b0);
      check("rst_rgb", {red, green, blue}, 12'h000);
    end

    // Prefetch at the end of the last line, then display line 0.
    reset    = 1'b1;
    wr_addr  = 15'd500;
    wr_data  = 12'h555;
    goto_px(16'd795, 16'd524);
    adv();
    adv();
    check("pf524_addr", ram_addr, 15'd0);
    check("pf524_we", ram_we, 1'b0);
    check("pf524_ready", wr_ready, 1'b0);
    adv();
    check("x798_ready", wr_ready, 1'b1);
    adv();
    adv();
    wr_valid = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      adv();
      exp_rgb = (i < 4) ? rgb444(4'hF, 4'h0, 4'h0) : rgb444(4'h0, 4'hF, 4'h0);
      check("line0_rgb", {red, green, blue}, exp_rgb);
    end

    // Writer streaming across the active line and into hblank.
    auto_wr  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 15'd1000;
    wr_data  = 12'h100;
    #1;
    for (int i = 0; i < 640; i++) begin
      check("stream_ready", wr_ready, !(px[1:0] == 2'd1 && px < 16'd636));
      prevx = px;
      adv();
      if (prevx >= 16'd636 && prevx <= 16'd643)
        check("edge_rgb", {red, green, blue}, (prevx < 16'd640) ? 12'hFFF : 12'h000);
    end
    auto_wr  = 1'b0;
    wr_valid = 1'b0;
    #1;
    check("stream_count", n_acc, 483);
    check("mem1000", mem[1000], 12'h100);
    check("mem1001", mem[1001], 12'h101);
    check("mem1482", mem[1482], 12'h2E2);
    check("mem1483", mem[1483], 12'h000);

    // Out-of-range write.
    wr_valid = 1'b1;
    wr_addr  = 15'd19200;
    wr_data  = 12'hFFF;
    #1;
    check("oor_ready", wr_ready, 1'b1);
    check("oor_we", ram_we, 1'b0);
    check("oor_err_pre", wr_err, 1'b0);
    adv();
    wr_valid = 1'b0;
    #1;
    check("oor_err", wr_err, 1'b1);
    adv();
    check("oor_err_clr", wr_err, 1'b0);
    check("oor_mem", mem[19200], 12'h000);

    // Boundary fetch decode.
    wr_valid = 1'b1;
    wr_addr  = 15'd50;
    wr_data  = 12'h321;
    goto_px(16'd797, 16'd479);
    check("pf479_ready", wr_ready, 1'b1);
    check("pf479_we", ram_we, 1'b1);
    check("pf479_addr", ram_addr, 15'd50);
    goto_px(16'd797, 16'd478);
    check("pf478_ready", wr_ready, 1'b0);
    check("pf478_addr", ram_addr, 15'd19040);
    goto_px(16'd5, 16'd8);
    check("y8x5_addr", ram_addr, 15'd322);
    check("y8x5_ready", wr_ready, 1'b0);
    goto_px(16'd637, 16'd8);
    check("grp159_ready", wr_ready, 1'b1);

    // Write then read back address 100.
    wr_addr = 15'd100;
    wr_data = 12'hABC;
    goto_px(16'd700, 16'd10);
    check("wb_ready", wr_ready, 1'b1);
    check("wb_we", ram_we, 1'b1);
    adv();
`ifdef VGA_ARB_READBACK_EN
    wr_cmd = 1'b1;
    #1;
    check("rd_we", ram_we, 1'b0);
    check("rd_ready", wr_ready, 1'b1);
    adv();
    wr_valid = 1'b0;
    wr_cmd   = 1'b0;
    #1;
    check("rd_valid", rd_valid, 1'b1);
    check("rd_data", rd_data, 12'hABC);
    adv();
    check("rd_valid_clr", rd_valid, 1'b0);
    wr_valid = 1'b1;
    wr_cmd   = 1'b1;
    wr_addr  = 15'd20000;
    #1;
    adv();
    wr_valid = 1'b0;
    wr_cmd   = 1'b0;
    #1;
    check("rd_oor_valid", rd_valid, 1'b1);
    check("rd_oor_data", rd_data, 12'h000);
    check("rd_oor_err", wr_err, 1'b1);
`else
    wr_valid = 1'b0;
    #1;
    check("wb_mem100", mem[100], 12'hABC);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
